// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction fetch queue between byte-wide code memory and decode.
//
// Prefetches up to 8 bytes starting at eip over a req/ack byte interface and
// presents the first four as the ope window. Retired instructions advance eip by
// num_of_ope bytes; jumps redirect the stream. A request that is in flight when
// the queue is flushed completes normally but its byte is discarded.
//
// Optional feature: define IFETCH_ERR_EN to add the sticky fetch_err output.
//
// Ports:
//   clk2        in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   mem_req     out  byte read request, held until mem_ack
//   mem_addr    out  byte address, stable while mem_req is high
//   mem_ack     in   read done, mem_rdata valid this cycle
//   mem_rdata   in   returned byte
//   ope         out  queue bytes 0..3, byte at eip in [31:24]
//   ope_valid   out  at least four bytes queued
//   num_of_ope  in   length of the current instruction
//   ope_done    in   retire pulse (honoured only while ope_valid)
//   jump_en     in   redirect pulse, wins over ope_done
//   jump_addr   in   new eip on jump
//   eip         out  address of queue byte 0
//   fetch_err   out  (IFETCH_ERR_EN only) sticky retire-protocol error
module ifetch_queue #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_EIP = '0
) (
  input  logic              clk2,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       ope,
  output logic              ope_valid,
  input  logic [3:0]        num_of_ope,
  input  logic              ope_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] eip
`ifdef IFETCH_ERR_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        queue_reg [8];
  logic [7:0]        queue_next [8];
  logic [7:0]        shifted [8];
  logic [3:0]        count_reg, count_next;
  logic [ADDR_W-1:0] eip_reg, eip_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] faddr_next;
  logic              drop_reg, drop_next;
  logic              valid_reg;
  logic              ack;
  logic              retire;
  logic              flush;

  // Queue contents shifted down by num_of_ope; vacated slots read as zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    logic [4:0] src;
    assign src         = 5'(gi) + {1'b0, num_of_ope};
    assign shifted[gi] = (src < 5'd8) ? queue_reg[src[2:0]] : 8'h00;
  end

  assign ack    = (state_reg == S_REQ) && mem_ack;
  assign retire = ope_done && valid_reg && !jump_en && (num_of_ope != 4'd0);

  // Queue, eip and drop-flag update. The retire/jump is applied first, then an
  // ack appends behind whatever survived (or is discarded on any flush).
  always_comb begin
    queue_next = queue_reg;
    count_next = count_reg;
    eip_next   = eip_reg;
    drop_next  = drop_reg;
    flush      = 1'b0;

    if (jump_en) begin
      flush      = 1'b1;
      count_next = 4'd0;
      eip_next   = jump_addr;
    end else if (retire) begin
      eip_next = eip_reg + ADDR_W'(num_of_ope);
      if (num_of_ope >= count_reg) begin
        flush      = 1'b1;
        count_next = 4'd0;
      end else begin
        count_next = count_reg - num_of_ope;
        queue_next = shifted;
      end
    end

    if (ack) begin
      // The request has completed, so any pending drop is consumed here.
      if (!flush && !drop_reg) begin
        queue_next[count_next[2:0]] = mem_rdata;
        count_next                  = count_next + 4'd1;
      end
      drop_next = 1'b0;
    end else if (flush && (state_reg == S_REQ)) begin
      drop_next = 1'b1;
    end
  end

  // Fetch pointer always tracks the end of the queue; after a flush this is the
  // new eip, so the request following a dropped byte lands at the right place.
  assign faddr_next = eip_next + ADDR_W'(count_next);

  // Fetch FSM. Decisions use the post-update count/pointer so a redirect on the
  // same edge never launches a request to a stale address.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (count_next < 4'd8) begin
          state_next = S_REQ;
          addr_next  = faddr_next;
        end
      end
      S_REQ: begin
        if (ack) begin
          if (count_next < 4'd8) begin
            addr_next = faddr_next;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      count_reg <= 4'd0;
      eip_reg   <= RESET_EIP;
      addr_reg  <= RESET_EIP;
      drop_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      eip_reg   <= eip_next;
      addr_reg  <= addr_next;
      drop_reg  <= drop_next;
      valid_reg <= (count_next >= 4'd4);
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_queue
    always_ff @(posedge clk2 or negedge reset_n) begin
      if (!reset_n) begin
        queue_reg[gi] <= 8'h00;
      end else begin
        queue_reg[gi] <= queue_next[gi];
      end
    end
  end

  assign mem_req   = (state_reg == S_REQ);
  assign mem_addr  = addr_reg;
  assign ope       = {queue_reg[0], queue_reg[1], queue_reg[2], queue_reg[3]};
  assign ope_valid = valid_reg;
  assign eip       = eip_reg;

`ifdef IFETCH_ERR_EN
  logic err_reg;

  // Sticky: a retire while the window is not valid, or a zero-length retire.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (ope_done && (!valid_reg || (num_of_ope == 4'd0))) begin
      err_reg <= 1'b1;
    end
  end

  assign fetch_err = err_reg;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue -- self-checking bench for ifetch_queue.
//
// A byte-queue reference model (SV queue of bytes plus eip) is advanced once
// per clock from the same inputs the DUT sees; a memory responder with
// programmable wait states feeds both. Directed scenarios are followed by a
// randomized phase. Define IFETCH_ERR_EN to also check fetch_err.
module tb_ifetch_queue;

  localparam logic [31:0] RST_EIP = 32'h0;

  logic        clk2;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] ope;
  logic        ope_valid;
  logic [3:0]  num_of_ope;
  logic        ope_done;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] eip;
`ifdef IFETCH_ERR_EN
  logic        fetch_err;
`endif

  ifetch_queue #(.ADDR_W(32), .RESET_EIP(RST_EIP)) dut (
    .clk2      (clk2),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ope       (ope),
    .ope_valid (ope_valid),
    .num_of_ope(num_of_ope),
    .ope_done  (ope_done),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .eip       (eip)
`ifdef IFETCH_ERR_EN
    ,
    .fetch_err (fetch_err)
`endif
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [31:0] m_eip;
  bit          m_stale;
  bit          m_err;
  logic [31:0] acc_addrs[$];

  // Memory responder state
  int          lat;
  int          wcnt;
  bit          prev_wait;
  logic [31:0] prev_addr;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h55;
      32'd1:   return 8'h89;
      32'd2:   return 8'hE5;
      32'd3:   return 8'hB8;
      32'd4:   return 8'h2A;
      32'd5:   return 8'h00;
      32'd6:   return 8'h00;
      32'd7:   return 8'h00;
      32'd8:   return 8'hC3;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk2);
    #2;
    reset_n    = 1'b0;
    ope_done   = 1'b0;
    num_of_ope = 4'd0;
    jump_en    = 1'b0;
    jump_addr  = 32'h0;
    mem_ack    = 1'b0;
    #1;
    check("rst_eip", 64'(eip), 64'(RST_EIP));
    check("rst_ope", 64'(ope), 64'd0);
    check("rst_ope_valid", 64'(ope_valid), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'(RST_EIP));
`ifdef IFETCH_ERR_EN
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
`endif
    mq.delete();
    m_eip     = RST_EIP;
    m_stale   = 1'b0;
    m_err     = 1'b0;
    wcnt      = 0;
    prev_wait = 1'b0;
    @(negedge clk2);
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs and the memory response at the falling edge,
  // advance the model, then check outputs just after the rising edge.
  task automatic step(input bit done, input logic [3:0] nb, input bit jmp, input logic [31:0] ja);
    bit valid_m;
    bit flush;
    bit ack_eff;
    @(negedge clk2);
    ope_done   = done;
    num_of_ope = nb;
    jump_en    = jmp;
    jump_addr  = ja;

    if (prev_wait) begin
      check("req_held", 64'(mem_req), 64'd1);
      check("addr_held", 64'(mem_addr), 64'(prev_addr));
    end
    if (mem_req) begin
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
        wcnt      = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;

    valid_m = (mq.size() >= 4);
    ack_eff = mem_req && mem_ack;
    flush   = 1'b0;
    if (done && (!valid_m || nb == 4'd0)) m_err = 1'b1;
    if (jmp) begin
      mq.delete();
      m_eip = ja;
      flush = 1'b1;
    end else if (done && valid_m && nb != 4'd0) begin
      m_eip = m_eip + 32'(nb);
      if (int'(nb) >= mq.size()) begin
        mq.delete();
        flush = 1'b1;
      end else begin
        repeat (nb) void'(mq.pop_front());
      end
    end
    if (ack_eff) begin
      if (flush || m_stale) begin
        m_stale = 1'b0;
      end else begin
        check("fetch_addr", 64'(mem_addr), 64'(32'(m_eip + 32'(mq.size()))));
        acc_addrs.push_back(mem_addr);
        mq.push_back(mem_rdata);
      end
    end else if (flush && mem_req) begin
      m_stale = 1'b1;
    end

    @(posedge clk2);
    #1;
    check("eip", 64'(eip), 64'(m_eip));
    check("ope_valid", 64'(ope_valid), 64'(mq.size() >= 4));
    for (int i = 0; i < 4 && i < mq.size(); i++) begin
      check("ope_byte", 64'(ope[31-8*i -: 8]), 64'(mq[i]));
    end
    if (mq.size() == 8) check("full_no_req", 64'(mem_req), 64'd0);
`ifdef IFETCH_ERR_EN
    check("fetch_err", 64'(fetch_err), 64'(m_err));
`endif
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!ope_valid && k < budget) begin
      idle();
      k++;
    end
    check(tag, 64'(ope_valid), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = 8'h00;
    ope_done   = 1'b0;
    num_of_ope = 4'd0;
    jump_en    = 1'b0;
    jump_addr  = 32'h0;
    lat        = 0;

    // Cold start with zero-wait memory
    do_reset();
    @(posedge clk2);
    #1;
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", 64'(mem_addr), 64'd0);
    wait_valid("cold_valid_timeout", 20);
    check("cold_ope", 64'(ope), 64'h5589E5B8);
    repeat (8) idle();
    check("cold_full_idle", 64'(mem_req), 64'd0);

    // Retire sequence 1, 2, 5, 1
    step(1'b1, 4'd1, 1'b0, 32'h0);
    check("ret1_eip", 64'(eip), 64'd1);
    check("ret1_ope", 64'(ope), 64'h89E5B82A);
    repeat (8) idle();
    step(1'b1, 4'd2, 1'b0, 32'h0);
    check("ret2_eip", 64'(eip), 64'd3);
    check("ret2_ope", 64'(ope), 64'hB82A0000);
    repeat (8) idle();
    step(1'b1, 4'd5, 1'b0, 32'h0);
    check("ret5_eip", 64'(eip), 64'd8);
    check("ret5_valid", 64'(ope_valid), 64'd0);
    check("ret5_ope_top", 64'(ope[31:24]), 64'hC3);
    wait_valid("ret5_refill_timeout", 20);
    step(1'b1, 4'd1, 1'b0, 32'h0);
    check("ret1b_eip", 64'(eip), 64'd9);

    // Retire beyond the queue: count = 4, n = 6
    lat = 2;
    do_reset();
    wait_valid("beyond_valid_timeout", 40);
    step(1'b1, 4'd6, 1'b0, 32'h0);
    check("beyond_eip", 64'(eip), 64'd6);
    check("beyond_valid", 64'(ope_valid), 64'd0);
    idle();
    idle();
    check("beyond_next_addr", 64'(mem_addr), 64'd6);
    wait_valid("beyond_refill_timeout", 60);

    // Jump while the request to 5 waits on a slow memory
    lat = 3;
    do_reset();
    begin
      int k = 0;
      while (!(mem_req && mem_addr == 32'd5) && k < 100) begin
        idle();
        k++;
      end
      check("jump_reach5_timeout", 64'(mem_req && mem_addr == 32'd5), 64'd1);
    end
    step(1'b0, 4'd0, 1'b1, 32'h100);
    check("jump_eip", 64'(eip), 64'h100);
    wait_valid("jump_valid_timeout", 100);
    check("jump_ope", 64'(ope),
          64'({mem_byte(32'h100), mem_byte(32'h101), mem_byte(32'h102), mem_byte(32'h103)}));
    check("jump_eip2", 64'(eip), 64'h100);

    // Retire and ack on the same edge with count = 5, then jump vs retire
    lat = 0;
    do_reset();
    begin
      int k = 0;
      while (mq.size() != 5 && k < 50) begin
        idle();
        k++;
      end
      check("simul_reach5_timeout", 64'(mq.size()), 64'd5);
    end
    step(1'b1, 4'd2, 1'b0, 32'h0);
    check("simul_ope", 64'(ope), 64'hE5B82A00);
    check("simul_eip", 64'(eip), 64'd2);
    check("simul_valid", 64'(ope_valid), 64'd1);
    step(1'b1, 4'd3, 1'b1, 32'h200);
    check("jump_wins_eip", 64'(eip), 64'h200);
    check("jump_wins_valid", 64'(ope_valid), 64'd0);

    // Address wrap
    acc_addrs.delete();
    step(1'b0, 4'd0, 1'b1, 32'hFFFFFFFE);
    wait_valid("wrap_valid_timeout", 20);
    check("wrap_addr0", 64'(acc_addrs[0]), 64'hFFFFFFFE);
    check("wrap_addr1", 64'(acc_addrs[1]), 64'hFFFFFFFF);
    check("wrap_addr2", 64'(acc_addrs[2]), 64'h0);
    check("wrap_addr3", 64'(acc_addrs[3]), 64'h1);
    step(1'b1, 4'd3, 1'b0, 32'h0);
    check("wrap_eip", 64'(eip), 64'h1);

    // Retire while the window is not valid is ignored
    do_reset();
    step(1'b1, 4'd1, 1'b0, 32'h0);
    check("early_retire_eip", 64'(eip), 64'(RST_EIP));
`ifdef IFETCH_ERR_EN
    check("err_set", 64'(fetch_err), 64'd1);
    repeat (10) idle();
    check("err_sticky", 64'(fetch_err), 64'd1);
`endif

    // Randomized traffic, with one asynchronous reset in the middle
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit          d;
      bit          j;
      logic [3:0]  nb;
      logic [31:0] ja;
      if (c % 40 == 0) lat = $urandom_range(0, 3);
      if (c == 750) do_reset();
      d  = ($urandom_range(0, 2) == 0);
      nb = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      j  = ($urandom_range(0, 39) == 0);
      ja = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      step(d, nb, j, ja);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch unit. It is the producer side of the decode interface: it supplies the 32-bit `ope` window to the decoder and consumes the decoder's `num_of_ope` byte count.
- It pulls instruction bytes from byte-wide code memory over a req/ack handshake. It holds up to 8 prefetched bytes starting at `eip`.
- On each retired instruction it advances `eip` by `num_of_ope` bytes. It sits between code memory and decode.

Parameters:
- ADDR_W, 32: width of `eip` and `mem_addr`. All address arithmetic is modulo 2^ADDR_W.
- RESET_EIP, 0: `eip` and the first fetch address after reset.

Ports:
- clk2  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  byte read request; held until acked.
- mem_addr  out  ADDR_W  byte address; stable while `mem_req` is high.
- mem_ack  in  1  read done; `mem_rdata` is valid this cycle.
- mem_rdata  in  8  returned byte.
- ope  out  32  `buf[0]`..`buf[3]`; `buf[0]` (byte at `eip`) in [31:24].
- ope_valid  out  1  high when `count` >= 4.
- num_of_ope  in  4  length of the current instruction, from decode.
- ope_done  in  1  1-cycle pulse: retire the current instruction.
- jump_en  in  1  1-cycle pulse: redirect the fetch stream.
- jump_addr  in  ADDR_W  new `eip` when `jump_en` is high.
- eip  out  ADDR_W  address of `buf[0]`.

Behaviour:
- Clock and reset: one clock (`clk2`). `reset_n` is asynchronous and active-low.
- Reset values:
  - `eip` = RESET_EIP.
  - `count` = 0, `ope` = 0, `ope_valid` = 0.
  - `mem_req` = 0, `mem_addr` = RESET_EIP.
  - Drop flag = 0, FSM = IDLE.
- Internal state:
  - Byte queue `buf[0..7]` and `count` (0..8).
  - Fetch pointer `faddr`, always equal to `eip + count`, except while a drop is pending.
- FSM, IDLE (`mem_req` = 0):
  - Go to REQ when `count` < 8.
  - `mem_addr` <= `faddr` on entry.
  - The first request is asserted in the first cycle after `reset_n` rises.
- FSM, REQ (`mem_req` = 1):
  - `mem_req` and `mem_addr` are held until `mem_ack`. A request is never withdrawn.
  - On an ack edge with no drop pending: `buf[count]` <= `mem_rdata`, `count` + 1.
  - After the ack: stay in REQ at address + 1 if the post-update `count` < 8 (back-to-back, 1 byte/cycle with zero-wait memory); otherwise go to IDLE.
- Retire: `ope_done` is honoured only when `ope_valid` = 1; otherwise it is ignored. Let n = `num_of_ope`.
  - n = 0: no advance.
  - 1 <= n < `count`: shift the queue down by n and set `count` = `count` - n. `eip` += n.
  - n >= `count`: flush the queue (`count` = 0) and set `faddr` = `eip` + n. `eip` += n.
- Jump: `jump_en` flushes the queue, sets `eip` = `faddr` = `jump_addr`, and `count` = 0.
  - `jump_en` has priority over `ope_done` in the same cycle.
- Flush with a request in flight: set the drop flag.
  - The request completes normally, but its byte is discarded and the flag cleared.
  - The next request goes to the new `faddr`.
- Ack in the same cycle as a retire without flush: the retire shift is applied first, then the byte is stored at `buf[count - n]`.
- Ack in the same cycle as any flush: the byte is discarded. No drop flag is set, because that request is already done.
- Outputs are registered. `ope` and `ope_valid` reflect the queue state after the clock edge.
- `eip`, `faddr` and `mem_addr` wrap from 2^ADDR_W - 1 to 0 with no special handling.
- Asserting `reset_n` low mid-request forces all reset values immediately. The memory side must tolerate the abandoned request.

Optional Feature:
- Macro IFETCH_ERR_EN.
- When defined, adds output `fetch_err` (1 bit, reset 0), a sticky flag. It is set on the edge where:
  - `ope_done` arrives with `ope_valid` = 0, or
  - `ope_done` arrives with `num_of_ope` = 0.
- `fetch_err` is cleared only by reset.
- When undefined, the port and its logic are absent. The retire behaviour is identical either way.

Test Plan:
- Reset / cold start: memory at 0 = 55 89 E5 B8 2A 00 00 00 C3, zero-wait ack.
  - `mem_req` rises 1 cycle after reset release; addresses are 0,1,2,…
  - `ope_valid` rises after the 4th ack with `ope` = 32'h5589E5B8.
  - The queue stops requesting once `count` = 8.
- Retire sequence: pulse `ope_done` with n = 1, 2, 5, 1.
  - `ope` steps through 89E5B82A, B82A0000, C3xxxxxx with `ope_valid` low until refilled.
  - `eip` steps through 1, 3, 8, 9.
- Retire beyond the queue: `count` = 4, `ope_done` with n = 6.
  - Queue flushes; `eip` = 6; next `mem_addr` = 6.
- Jump during a wait-state request: 3-cycle ack latency, `jump_en` with `jump_addr` = 32'h100 while the request to 5 is pending.
  - The byte from 5 is dropped; the next request goes to 32'h100.
  - `ope` = bytes 100..103; `eip` = 32'h100.
- Simultaneous events:
  - `ope_done` (n = 2) and `mem_ack` on the same edge with `count` = 5: the new byte lands at `buf[3]`, `count` = 4.
  - `jump_en` and `ope_done` together: the jump wins.
- Wrap and error flag: RESET_EIP = 32'hFFFFFFFE; fetch addresses go FFFFFFFE, FFFFFFFF, 0, 1.
  - With IFETCH_ERR_EN: `ope_done` while `ope_valid` = 0 sets `fetch_err` = 1, which stays set until reset.
